// File: rtl/stopwatch_disp_pkg.sv
// Shared constants and helpers for the stopwatch MM.SS seven-segment display mux.
// Segment bytes are active low in {dp,g,f,e,d,c,b,a} order; anodes are active low.
package stopwatch_disp_pkg;

    localparam logic [7:0] SEG_0    = 8'hC0;
    localparam logic [7:0] SEG_1    = 8'hF9;
    localparam logic [7:0] SEG_2    = 8'hA4;
    localparam logic [7:0] SEG_3    = 8'hB0;
    localparam logic [7:0] SEG_4    = 8'h99;
    localparam logic [7:0] SEG_5    = 8'h92;
    localparam logic [7:0] SEG_6    = 8'h82;
    localparam logic [7:0] SEG_7    = 8'hF8;
    localparam logic [7:0] SEG_8    = 8'h80;
    localparam logic [7:0] SEG_9    = 8'h90;
    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_OFF  = 8'hFF;

    localparam logic [3:0] AN_OFF      = 4'b1111;
    localparam logic [3:0] AN_MIN_TENS = 4'b0111;
    localparam logic [3:0] AN_MIN_ONES = 4'b1011;
    localparam logic [3:0] AN_SEC_TENS = 4'b1101;
    localparam logic [3:0] AN_SEC_ONES = 4'b1110;

    localparam logic [5:0] MAX_FIELD = 6'd59;

    // Scan index doubles as the FSM state; the encoding is the digit slot number.
    typedef enum logic [1:0] {
        IDX_MIN_TENS = 2'd0,
        IDX_MIN_ONES = 2'd1,
        IDX_SEC_TENS = 2'd2,
        IDX_SEC_ONES = 2'd3
    } scan_idx_e;

    typedef struct packed {
        scan_idx_e idx;
        logic      blank_phase;
    } scan_state_t;

    function automatic logic [3:0] bcd_tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

endpackage

// File: rtl/stopwatch_display_mux_seg_decoder.sv
// Combinational digit-to-segment decoder; returns the seven active-low segments {g..a}.
// Dash overrides the digit; codes above 9 decode to all segments off.
module seg_decoder
    import stopwatch_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       dash_i,
    output logic [6:0] pattern_o
);

    always_comb begin
        pattern_o = SEG_OFF[6:0];
        if (dash_i) begin
            pattern_o = SEG_DASH[6:0];
        end else begin
            case (digit_i)
                4'd0:    pattern_o = SEG_0[6:0];
                4'd1:    pattern_o = SEG_1[6:0];
                4'd2:    pattern_o = SEG_2[6:0];
                4'd3:    pattern_o = SEG_3[6:0];
                4'd4:    pattern_o = SEG_4[6:0];
                4'd5:    pattern_o = SEG_5[6:0];
                4'd6:    pattern_o = SEG_6[6:0];
                4'd7:    pattern_o = SEG_7[6:0];
                4'd8:    pattern_o = SEG_8[6:0];
                4'd9:    pattern_o = SEG_9[6:0];
                default: pattern_o = SEG_OFF[6:0];
            endcase
        end
    end

endmodule

// File: rtl/stopwatch_display_mux.sv
// Four-digit MM.SS multiplexer: one digit per refresh tick, frame-coherent snapshot,
// and blinking of the field under adjustment.
module stopwatch_display_mux
    import stopwatch_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] mincounter,
    input  logic [5:0] seccounter,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] an,
    output logic [7:0] seg
);

    localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    logic [RW-1:0] refresh_q;
    logic [BW-1:0] blink_q;
    scan_state_t   scan_q;
    logic [5:0]    snap_min_q;
    logic [5:0]    snap_sec_q;
    logic [3:0]    an_q;
    logic [7:0]    seg_q;

    logic          tick;
    logic          blink_wrap;
    scan_idx_e     idx_next;
    logic [5:0]    digit_val;
    logic          take_tens;
    logic          dp_on;
    logic          sec_field;
    logic [3:0]    an_slot;
    logic [3:0]    dec_digit;
    logic          dec_dash;
    logic [6:0]    dec_pattern;
    logic [3:0]    an_d;
    logic [7:0]    seg_d;

    assign tick       = (refresh_q == REFRESH_LAST);
    assign blink_wrap = (blink_q == BLINK_LAST);

    // Slot 0 reads the live minutes because the snapshot is only being loaded on that edge.
    always_comb begin
        idx_next  = scan_idx_e'(scan_q.idx + 2'd1);
        digit_val = snap_sec_q;
        take_tens = 1'b0;
        dp_on     = 1'b0;
        sec_field = 1'b1;
        an_slot   = AN_SEC_ONES;
        case (idx_next)
            IDX_MIN_TENS: begin
                digit_val = mincounter;
                take_tens = 1'b1;
                sec_field = 1'b0;
                an_slot   = AN_MIN_TENS;
            end
            IDX_MIN_ONES: begin
                digit_val = snap_min_q;
                dp_on     = 1'b1;
                sec_field = 1'b0;
                an_slot   = AN_MIN_ONES;
            end
            IDX_SEC_TENS: begin
                digit_val = snap_sec_q;
                take_tens = 1'b1;
                an_slot   = AN_SEC_TENS;
            end
            default: begin
                digit_val = snap_sec_q;
                an_slot   = AN_SEC_ONES;
            end
        endcase
        dec_digit = take_tens ? bcd_tens(digit_val) : bcd_ones(digit_val);
        dec_dash  = (digit_val > MAX_FIELD);
    end

    seg_decoder u_seg_decoder (
        .digit_i   (dec_digit),
        .dash_i    (dec_dash),
        .pattern_o (dec_pattern)
    );

    always_comb begin
        an_d  = an_slot;
        seg_d = {~dp_on, dec_pattern};
        if (adj && scan_q.blank_phase && (sec_field == sel)) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q          <= '0;
            blink_q            <= '0;
            scan_q.idx         <= IDX_SEC_ONES;
            scan_q.blank_phase <= 1'b0;
            snap_min_q         <= '0;
            snap_sec_q         <= '0;
            an_q               <= AN_OFF;
            seg_q              <= SEG_OFF;
        end else begin
            refresh_q <= tick ? '0 : refresh_q + RW'(1);
            if (blink_wrap) begin
                blink_q            <= '0;
                scan_q.blank_phase <= ~scan_q.blank_phase;
            end else begin
                blink_q <= blink_q + BW'(1);
            end
            if (tick) begin
                scan_q.idx <= idx_next;
                an_q       <= an_d;
                seg_q      <= seg_d;
                if (idx_next == IDX_MIN_TENS) begin
                    snap_min_q <= mincounter;
                    snap_sec_q <= seccounter;
                end
            end
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// Directed bench for stopwatch_display_mux with REFRESH_DIV=4, BLINK_DIV=32.
// Frame vectors are applied back-to-back from one reset so blink phase is known per frame.
module tb_stopwatch_display_mux;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] mincounter;
    logic [5:0] seccounter;
    logic       adj;
    logic       sel;
    logic [3:0] an;
    logic [7:0] seg;

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] exp_q[$];

    typedef struct packed {
        logic [5:0]  min;
        logic [5:0]  sec;
        logic        mid_en;
        logic [5:0]  sec_mid;
        logic        adj;
        logic        sel;
        logic [15:0] an_exp;
        logic [31:0] seg_exp;
    } frame_vec_t;

    frame_vec_t vecs[12];

    stopwatch_display_mux #(
        .REFRESH_DIV (4),
        .BLINK_DIV   (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mincounter (mincounter),
        .seccounter (seccounter),
        .adj        (adj),
        .sel        (sel),
        .an         (an),
        .seg        (seg)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, an=%b seg=%h", an, seg);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [3:0] an_e, input logic [7:0] seg_e);
        n_cmp++;
        if (an !== an_e || seg !== seg_e) begin
            n_err++;
            $display("FAIL %s: got an=%b seg=%h, want an=%b seg=%h", name, an, seg, an_e, seg_e);
        end
    endtask

    task automatic set_vec(input int k, input logic [5:0] mn, input logic [5:0] sc,
                           input logic mid_en, input logic [5:0] sec_mid,
                           input logic a, input logic s,
                           input logic [15:0] an_e, input logic [31:0] seg_e);
        vecs[k] = '{min: mn, sec: sc, mid_en: mid_en, sec_mid: sec_mid, adj: a, sel: s,
                    an_exp: an_e, seg_exp: seg_e};
    endtask

    initial begin
        logic [11:0] exp;

        // Frames 2,3,6,7,10,11 fall in the blank half of the blink period.
        set_vec(0,  6'd12, 6'd34, 1'b0, 6'd0,  1'b0, 1'b0, 16'h7BDE, 32'hF924B099);
        set_vec(1,  6'd12, 6'd34, 1'b1, 6'd35, 1'b0, 1'b0, 16'h7BDE, 32'hF924B099);
        set_vec(2,  6'd12, 6'd35, 1'b0, 6'd0,  1'b0, 1'b0, 16'h7BDE, 32'hF924B092);
        set_vec(3,  6'd12, 6'd35, 1'b0, 6'd0,  1'b1, 1'b1, 16'h7BFF, 32'hF924FFFF);
        set_vec(4,  6'd12, 6'd35, 1'b0, 6'd0,  1'b1, 1'b1, 16'h7BDE, 32'hF924B092);
        set_vec(5,  6'd12, 6'd35, 1'b0, 6'd0,  1'b1, 1'b0, 16'h7BDE, 32'hF924B092);
        set_vec(6,  6'd12, 6'd35, 1'b0, 6'd0,  1'b1, 1'b0, 16'hFFDE, 32'hFFFFB092);
        set_vec(7,  6'd12, 6'd35, 1'b0, 6'd0,  1'b0, 1'b0, 16'h7BDE, 32'hF924B092);
        set_vec(8,  6'd59, 6'd60, 1'b0, 6'd0,  1'b0, 1'b0, 16'h7BDE, 32'h9210BFBF);
        set_vec(9,  6'd60, 6'd7,  1'b0, 6'd0,  1'b0, 1'b0, 16'h7BDE, 32'hBF3FC0F8);
        set_vec(10, 6'd0,  6'd59, 1'b0, 6'd0,  1'b1, 1'b1, 16'h7BFF, 32'hC040FFFF);
        set_vec(11, 6'd45, 6'd9,  1'b0, 6'd0,  1'b0, 1'b0, 16'h7BDE, 32'h9912C090);

        rst        = 1'b1;
        mincounter = 6'd12;
        seccounter = 6'd34;
        adj        = 1'b0;
        sel        = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("reset_hold%0d", i), 4'b1111, 8'hFF);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("post_reset_dark%0d", i), 4'b1111, 8'hFF);
        end

        for (int k = 0; k < 12; k++) begin
            mincounter = vecs[k].min;
            seccounter = vecs[k].sec;
            adj        = vecs[k].adj;
            sel        = vecs[k].sel;
            for (int s = 0; s < 4; s++) begin
                exp_q.push_back({vecs[k].an_exp[15-4*s -: 4], vecs[k].seg_exp[31-8*s -: 8]});
            end
            for (int s = 0; s < 4; s++) begin
                exp = exp_q.pop_front();
                for (int c = 0; c < 4; c++) begin
                    step();
                    check($sformatf("frame%0d_slot%0d_cyc%0d", k, s, c), exp[11:8], exp[7:0]);
                    if (vecs[k].mid_en && s == 1 && c == 1) begin
                        seccounter = vecs[k].sec_mid;
                    end
                end
            end
        end

        mincounter = 6'd12;
        seccounter = 6'd34;
        adj        = 1'b0;
        sel        = 1'b0;
        repeat (9) step();
        check("midscan_slot2", 4'b1101, 8'hB0);
        rst = 1'b1;
        step();
        check("midscan_reset_edge", 4'b1111, 8'hFF);
        step();
        check("midscan_reset_hold", 4'b1111, 8'hFF);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("midscan_release_dark%0d", i), 4'b1111, 8'hFF);
        end
        step();
        check("midscan_first_lit", 4'b0111, 8'hF9);
        repeat (3) step();
        check("midscan_slot0_hold", 4'b0111, 8'hF9);
        step();
        check("midscan_slot1", 4'b1011, 8'h24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
